a2d_rr_intf: RTL and testbench
==============================

// Module: a2d_rr_intf
// PURPOSE
//  Round-robin A/D converter sequencer; sits directly upstream of the 16-bit SPI master and consumes its results.
//  Each conversion is two SPI transactions: the first sends the channel command, the second clocks out the 12-bit result.
//  Holds the latest result per channel (4 slots) for the balance/steer/battery logic.
// PARAMETERS
//  CH0         3'd0    A/D channel number for slot 0 (left load cell)
//  CH1         3'd4    A/D channel number for slot 1 (right load cell)
//  CH2         3'd5    A/D channel number for slot 2 (battery)
//  CH3         3'd6    A/D channel number for slot 3 (steer pot)
//  AUTO_PERIOD 20'd1_000_000  clk cycles between auto-started conversions (only with A2D_AUTO_CONV_EN)
// PORTS
//  clk          in   1   system clock, 50 MHz
//  rst_n        in   1   reset, asynchronous, active-low
//  nxt          in   1   1-clk pulse: start conversion of the current slot
//  spi_done     in   1   SPI master done; level, cleared by the master on the clk edge that samples spi_wrt
//  spi_rd_data  in   16  SPI master received data; valid while spi_done=1
//  spi_wrt      out  1   1-clk pulse to start an SPI transaction
//  spi_cmd      out  16  command to SPI master = {2'b00, chnl[2:0], 11'h000}
//  busy         out  1   high from the clk after nxt is accepted until cnv_cmplt
//  cnv_cmplt    out  1   1-clk pulse when a result is written
//  slot         out  2   slot index of the next/current conversion
//  res0..res3   out  12  latest result per slot
// BEHAVIOUR
//  Reset: state=IDLE, slot=0, res0..res3=12'h000, spi_wrt=0, spi_cmd=16'h0000, busy=0, cnv_cmplt=0.
//  spi_cmd is registered; it is loaded with the selected channel together with each spi_wrt and then held.
//  FSM states and transitions:
//   IDLE : nxt=1 -> spi_wrt=1, spi_cmd=cmd(slot), -> CMD.
//   CMD  : wait spi_done=1 (first transaction done; data discarded) -> GAP.
//   GAP  : exactly 1 clk with spi_wrt=0; then spi_wrt=1, same spi_cmd, -> READ.
//   READ : spi_done=1 -> res[slot] <= spi_rd_data[11:0], cnv_cmplt=1, slot <= slot+1 (wraps 3->0), -> IDLE.
//  Bits [15:12] of spi_rd_data are ignored.
//  spi_done is high in the clk of spi_wrt (left from the previous transaction) and is not a completion; completion is spi_done=1 while in CMD or READ.
//  Latency: nxt to cnv_cmplt = 2 SPI transactions + 3 clk (~1100 clk with a 1/32 SCLK).
//  nxt while busy: ignored, not queued. nxt in the same clk as cnv_cmplt: ignored.
//  res registers change only on cnv_cmplt; other slots are untouched.
//  Async reset mid-transaction: the FSM returns to IDLE immediately and all results clear.
//   The SPI master is reset by the same rst_n.
// CONFIGURATION
//  A2D_AUTO_CONV_EN defined:
//   - adds an internal 20-bit counter that wraps at AUTO_PERIOD-1.
//   - the wrap acts as nxt; the external nxt is still ORed in.
//   - the counter resets to 0 and runs continuously, including while busy; a wrap while busy is dropped.
//  Not defined: no counter; conversions start only on nxt.
// TESTING
//  T1 reset: rst_n=0 -> res0..3=0, slot=0, spi_wrt=0, busy=0.
//  T2 single conversion: nxt in slot 0, slave model returns 16'hFABC on the 2nd transaction
//     -> spi_cmd=16'h0000 on both wrts; res0=12'hABC; slot=1; cnv_cmplt pulses once.
//  T3 wrap: 5 conversions with data 1,2,3,4,5
//     -> cmds 0x0000,0x2000,0x2800,0x3000,0x0000; final res0=5, res1=2, res2=3, res3=4.
//  T4 nxt while busy: a second nxt 100 clk after the first -> exactly 2 spi_wrt total, 1 cnv_cmplt.
//  T5 reset mid-READ: pull rst_n low during the 2nd transaction -> busy=0, res=0;
//     the next nxt restarts at slot 0.
//  T6 A2D_AUTO_CONV_EN with AUTO_PERIOD=2000, nxt tied 0
//     -> cnv_cmplt every 2000 clk; slots cycle 0..3.

Source files
------------

// File: rtl/a2d_rr_intf_if.sv
// ---------------------------------------------------------------------------
// a2d_rr_intf_if
//   Bundles the link between the A/D round-robin sequencer and the 16-bit
//   SPI master.
//
//   Handshake: the sequencer raises spi_wrt for exactly one clk with spi_cmd
//   already valid. That is the request, and it is never back-pressured. The
//   SPI master clears spi_done on the clk edge that samples spi_wrt. It raises
//   spi_done again, and holds it, when the transaction finishes. spi_rd_data
//   is valid while spi_done=1. A spi_done that is still high in the clk of
//   spi_wrt is left over from the previous transaction. It does not mean the
//   new transaction has finished.
//
//   Signals
//     spi_wrt      sequencer -> SPI  1-clk start pulse
//     spi_cmd      sequencer -> SPI  16-bit command word (held after spi_wrt)
//     spi_done     SPI -> sequencer  transaction complete (level)
//     spi_rd_data  SPI -> sequencer  received word
//   Modports: master = sequencer side, slave = SPI master side.
// ---------------------------------------------------------------------------
interface a2d_rr_intf_if;
    logic        spi_wrt;
    logic [15:0] spi_cmd;
    logic        spi_done;
    logic [15:0] spi_rd_data;

    modport master (output spi_wrt, output spi_cmd,
                    input  spi_done, input spi_rd_data);
    modport slave  (input  spi_wrt, input spi_cmd,
                    output spi_done, output spi_rd_data);
endinterface

// File: rtl/a2d_rr_intf.sv
// ---------------------------------------------------------------------------
// a2d_rr_intf
//   Round-robin A/D conversion sequencer. It sits upstream of the 16-bit SPI
//   master. Each conversion takes two SPI transactions:
//     1. send the channel command (the returned word is discarded);
//     2. resend the same command and keep the returned 12-bit result.
//   The latest result for each of the four slots is held for downstream logic.
//
//   Optional feature (macro A2D_AUTO_CONV_EN)
//     When this macro is defined, a free-running 20-bit counter wraps every
//     AUTO_PERIOD clk. Each wrap starts a conversion, ORed with nxt.
//
//   Ports
//     clk          in   system clock
//     rst_n        in   asynchronous active-low reset
//     nxt          in   1-clk pulse: convert the current slot
//     spi          if   SPI master link (master modport)
//     busy         out  conversion in progress
//     cnv_cmplt    out  1-clk pulse when a result is written
//     slot         out  slot index of the next/current conversion
//     res0..res3   out  latest 12-bit result per slot
//     state_dbg    out  FSM state (0 IDLE, 1 CMD, 2 GAP, 3 READ)
// ---------------------------------------------------------------------------
module a2d_rr_intf #(
    parameter logic [2:0] CH0 = 3'd0,   // left load cell
    parameter logic [2:0] CH1 = 3'd4,   // right load cell
    parameter logic [2:0] CH2 = 3'd5,   // battery
    parameter logic [2:0] CH3 = 3'd6    // steer pot
`ifdef A2D_AUTO_CONV_EN
    , parameter logic [19:0] AUTO_PERIOD = 20'd1_000_000
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 nxt,
    a2d_rr_intf_if.master        spi,
    output logic                 busy,
    output logic                 cnv_cmplt,
    output logic [1:0]           slot,
    output logic [11:0]          res0,
    output logic [11:0]          res1,
    output logic [11:0]          res2,
    output logic [11:0]          res3,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        GAP  = 2'd2,
        READ = 2'd3
    } state_t;

    state_t     state;
    logic       start;
    logic [2:0] chnl;

    // The top nibble of the returned word carries no result bits.
    logic unused_rd_hi;
    assign unused_rd_hi = ^spi.spi_rd_data[15:12];

`ifdef A2D_AUTO_CONV_EN
    // Free-running period counter. A wrap that lands while busy is lost.
    logic [19:0] auto_cnt;
    logic        auto_wrap;

    assign auto_wrap = (auto_cnt == AUTO_PERIOD - 20'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_cnt <= 20'd0;
        end else if (auto_wrap) begin
            auto_cnt <= 20'd0;
        end else begin
            auto_cnt <= auto_cnt + 20'd1;
        end
    end

    assign start = nxt | auto_wrap;
`else
    assign start = nxt;
`endif

    always_comb begin
        chnl = CH0;
        case (slot)
            2'd0:    chnl = CH0;
            2'd1:    chnl = CH1;
            2'd2:    chnl = CH2;
            default: chnl = CH3;
        endcase
    end

    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            slot        <= 2'd0;
            busy        <= 1'b0;
            cnv_cmplt   <= 1'b0;
            spi.spi_wrt <= 1'b0;
            spi.spi_cmd <= 16'h0000;
            res0        <= 12'h000;
            res1        <= 12'h000;
            res2        <= 12'h000;
            res3        <= 12'h000;
        end else begin
            spi.spi_wrt <= 1'b0;
            cnv_cmplt   <= 1'b0;
            case (state)
                IDLE: begin
                    // A start that coincides with the completion pulse is dropped.
                    if (start && !cnv_cmplt) begin
                        spi.spi_wrt <= 1'b1;
                        spi.spi_cmd <= {2'b00, chnl, 11'h000};
                        busy        <= 1'b1;
                        state       <= CMD;
                    end
                end
                CMD: begin
                    // spi_done in the spi_wrt clk is stale, so it is ignored.
                    if (!spi.spi_wrt && spi.spi_done) begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    // spi_cmd still holds this slot's command.
                    spi.spi_wrt <= 1'b1;
                    state       <= READ;
                end
                READ: begin
                    if (!spi.spi_wrt && spi.spi_done) begin
                        case (slot)
                            2'd0:    res0 <= spi.spi_rd_data[11:0];
                            2'd1:    res1 <= spi.spi_rd_data[11:0];
                            2'd2:    res2 <= spi.spi_rd_data[11:0];
                            default: res3 <= spi.spi_rd_data[11:0];
                        endcase
                        cnv_cmplt <= 1'b1;
                        busy      <= 1'b0;
                        slot      <= slot + 2'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_rr_intf.sv
// ---------------------------------------------------------------------------
// tb_a2d_rr_intf
//   Bench for a2d_rr_intf. An SPI-master responder returns a junk word on the
//   first transaction of each pair and the chosen result on the second.
//   Expected command words are queued and compared on every spi_wrt.
//   A slot/result model predicts res0..res3 and slot.
// ---------------------------------------------------------------------------
module tb_a2d_rr_intf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        nxt = 1'b0;
    logic        busy;
    logic        cnv_cmplt;
    logic [1:0]  slot;
    logic [11:0] res0, res1, res2, res3;
    logic [1:0]  state_dbg;

    a2d_rr_intf_if spi_if ();

`ifdef A2D_AUTO_CONV_EN
    a2d_rr_intf #(.AUTO_PERIOD(20'd2000)) dut (
`else
    a2d_rr_intf dut (
`endif
        .clk       (clk),
        .rst_n     (rst_n),
        .nxt       (nxt),
        .spi       (spi_if.master),
        .busy      (busy),
        .cnv_cmplt (cnv_cmplt),
        .slot      (slot),
        .res0      (res0),
        .res1      (res1),
        .res2      (res2),
        .res3      (res3),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    always #10 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] exp_q[$];
    logic [11:0] ref_res[4];
    int          ref_slot;
    logic [2:0]  ch_map[4];

    int wrt_cnt    = 0;
    int cmplt_cnt  = 0;
    int cyc        = 0;
    int last_cmplt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [15:0] exp_cmd(input int s);
        return {2'b00, ch_map[s], 11'h000};
    endfunction

    // ---------------- SPI master responder ----------------
    int          txn_idx;
    int          len_cnt;
    int          len_lo = 60;
    int          len_hi = 120;
    logic [15:0] next_result = 16'h0000;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_if.spi_done    <= 1'b0;
            spi_if.spi_rd_data <= 16'h0000;
            txn_idx            <= 0;
            len_cnt            <= 0;
        end else if (spi_if.spi_wrt) begin
            spi_if.spi_done <= 1'b0;
            len_cnt         <= int'($urandom_range(len_hi, len_lo));
        end else if (len_cnt > 0) begin
            len_cnt <= len_cnt - 1;
            if (len_cnt == 1) begin
                spi_if.spi_done    <= 1'b1;
                spi_if.spi_rd_data <= txn_idx[0] ? next_result : 16'($urandom);
                txn_idx            <= txn_idx + 1;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (spi_if.spi_wrt) begin
                wrt_cnt++;
                if (exp_q.size() == 0) check("spi_wrt_extra", {31'b0, spi_if.spi_wrt}, 32'd0);
                else check("spi_cmd", {16'b0, spi_if.spi_cmd}, {16'b0, exp_q.pop_front()});
            end
            if (cnv_cmplt) begin
                cmplt_cnt++;
                last_cmplt = cyc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_all(input string tag);
        check({tag, "_res0"}, {20'b0, res0}, {20'b0, ref_res[0]});
        check({tag, "_res1"}, {20'b0, res1}, {20'b0, ref_res[1]});
        check({tag, "_res2"}, {20'b0, res2}, {20'b0, ref_res[2]});
        check({tag, "_res3"}, {20'b0, res3}, {20'b0, ref_res[3]});
        check({tag, "_slot"}, {30'b0, slot}, ref_slot);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) ref_res[i] = 12'h000;
        ref_slot = 0;
        exp_q.delete();
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Wait (bounded) until cnv_cmplt is seen at a negedge.
    task automatic wait_cmplt(input int budget);
        int n = 0;
        while (cnv_cmplt !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check("cmplt_timeout", {31'b0, cnv_cmplt}, 32'd1);
    endtask

    // One conversion. extra_dly > 0 fires a second nxt that many clk after
    // the first (it must be ignored). nxt_at_cmplt drives nxt in the
    // cnv_cmplt clk (it must be ignored too).
    task automatic do_conv(input logic [15:0] data, input int extra_dly, input bit nxt_at_cmplt);
        int w0, c0;
        w0 = wrt_cnt;
        c0 = cmplt_cnt;
        next_result = data;
        exp_q.push_back(exp_cmd(ref_slot));
        exp_q.push_back(exp_cmd(ref_slot));
        nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
        check("busy_after_nxt", {31'b0, busy}, 32'd1);
        if (extra_dly > 0) begin
            repeat (extra_dly - 1) @(negedge clk);
            check("busy_before_2nd_nxt", {31'b0, busy}, 32'd1);
            nxt = 1'b1;
            @(negedge clk);
            nxt = 1'b0;
        end
        wait_cmplt(3000);
        ref_res[ref_slot] = data[11:0];
        ref_slot = (ref_slot + 1) % 4;
        check("busy_at_cmplt", {31'b0, busy}, 32'd0);
        if (nxt_at_cmplt) nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
        check("cmplt_one_clk", {31'b0, cnv_cmplt}, 32'd0);
        repeat (4) @(negedge clk);
        check("cmplt_count", cmplt_cnt - c0, 32'd1);
        check("wrt_count", wrt_cnt - w0, 32'd2);
        check("state_idle", {30'b0, state_dbg}, 32'd0);
        check_all("conv");
    endtask

    // ---------------- main sequence ----------------
    initial begin
        ch_map[0] = 3'd0;
        ch_map[1] = 3'd4;
        ch_map[2] = 3'd5;
        ch_map[3] = 3'd6;
        model_reset();

        // T1 reset
        repeat (3) @(negedge clk);
        check("rst_spi_wrt", {31'b0, spi_if.spi_wrt}, 32'd0);
        check("rst_spi_cmd", {16'b0, spi_if.spi_cmd}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_cmplt", {31'b0, cnv_cmplt}, 32'd0);
        check_all("rst");
        rst_n = 1'b1;
        @(negedge clk);

`ifdef A2D_AUTO_CONV_EN
        // T6 auto conversions, nxt tied low, fixed SPI length
        len_lo = 50;
        len_hi = 50;
        for (int k = 0; k < 6; k++) begin
            int prev;
            prev = last_cmplt;
            next_result = 16'($urandom);
            exp_q.push_back(exp_cmd(ref_slot));
            exp_q.push_back(exp_cmd(ref_slot));
            wait_cmplt(2600);
            if (k > 0) check("auto_period", last_cmplt - prev, 32'd2000);
            ref_res[ref_slot] = next_result[11:0];
            ref_slot = (ref_slot + 1) % 4;
            @(negedge clk);
            check_all("auto");
        end
`else
        // T2 single conversion
        do_conv(16'hFABC, 0, 1'b0);
        check("t2_res0", {20'b0, res0}, 32'h0ABC);

        // T3 wrap from slot 0
        reset_dut();
        for (int k = 1; k <= 5; k++) do_conv(16'(k), 0, 1'b0);

        // T4 nxt while busy
        do_conv(16'($urandom), 100, 1'b0);

        // nxt in the cnv_cmplt clk, plus random traffic
        for (int k = 0; k < 6; k++)
            do_conv(16'($urandom), 0, (k % 2) == 0);

        // T5 reset during the second transaction
        begin
            int n = 0;
            int w0;
            w0 = wrt_cnt;
            next_result = 16'($urandom);
            exp_q.push_back(exp_cmd(ref_slot));
            exp_q.push_back(exp_cmd(ref_slot));
            nxt = 1'b1;
            @(negedge clk);
            nxt = 1'b0;
            while (wrt_cnt < w0 + 2 && n < 3000) begin
                @(negedge clk);
                n++;
            end
            check("t5_second_wrt", wrt_cnt - w0, 32'd2);
            repeat (10) @(negedge clk);
            #3 rst_n = 1'b0;
            model_reset();
            #1;
            check("t5_busy", {31'b0, busy}, 32'd0);
            check("t5_state", {30'b0, state_dbg}, 32'd0);
            check_all("t5");
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            do_conv(16'($urandom), 0, 1'b0);
        end
`endif

        check("exp_q_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
